// File: rtl/mux_2_4_8.sv
// -----------------------------------------------------------------------------
// mux_2_4_8
//
// Three independent data-lane multiplexers (2:1, 4:1, 8:1). Each lane has a
// purely combinational result and a registered copy of that result, giving
// one cycle of latency on the registered path.
//
// Ports
//   clk     in   1          system clock, registers update on rising edge
//   rst_n   in   1          asynchronous active-low reset (registered outs only)
//   in0     in   WIDTH      2:1 lane, input 0
//   in1     in   WIDTH      2:1 lane, input 1
//   sel2    in   1          2:1 select
//   in4     in   4*WIDTH    4:1 lane inputs, slice k = in4[k*WIDTH +: WIDTH]
//   sel4    in   2          4:1 select
//   in8     in   8*WIDTH    8:1 lane inputs, slice k = in8[k*WIDTH +: WIDTH]
//   sel8    in   3          8:1 select
//   out2    out  WIDTH      combinational 2:1 result
//   out4    out  WIDTH      combinational 4:1 result
//   out8    out  WIDTH      combinational 8:1 result
//   out2_q  out  WIDTH      out2 registered
//   out4_q  out  WIDTH      out4 registered
//   out8_q  out  WIDTH      out8 registered
// -----------------------------------------------------------------------------
module mux_2_4_8 #(
    parameter int WIDTH = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     in0,
    input  logic [WIDTH-1:0]     in1,
    input  logic                 sel2,
    input  logic [4*WIDTH-1:0]   in4,
    input  logic [1:0]           sel4,
    input  logic [8*WIDTH-1:0]   in8,
    input  logic [2:0]           sel8,
    output logic [WIDTH-1:0]     out2,
    output logic [WIDTH-1:0]     out4,
    output logic [WIDTH-1:0]     out8,
    output logic [WIDTH-1:0]     out2_q,
    output logic [WIDTH-1:0]     out4_q,
    output logic [WIDTH-1:0]     out8_q
);

    // Every select encoding addresses an existing slice, so an indexed part
    // select covers the whole select space with no out-of-range leg.
    function automatic logic [WIDTH-1:0] pick4(
        input logic [4*WIDTH-1:0] vec,
        input logic [1:0]         sel
    );
        return vec[int'(sel)*WIDTH +: WIDTH];
    endfunction

    function automatic logic [WIDTH-1:0] pick8(
        input logic [8*WIDTH-1:0] vec,
        input logic [2:0]         sel
    );
        return vec[int'(sel)*WIDTH +: WIDTH];
    endfunction

    logic [WIDTH-1:0] out2_d;
    logic [WIDTH-1:0] out4_d;
    logic [WIDTH-1:0] out8_d;

    // Combinational lane selection; independent of clk and rst_n.
    always_comb begin
        out2_d = {WIDTH{1'b0}};
        out4_d = {WIDTH{1'b0}};
        out8_d = {WIDTH{1'b0}};
        if (sel2 == 1'b1) begin
            out2_d = in1;
        end else begin
            out2_d = in0;
        end
        out4_d = pick4(in4, sel4);
        out8_d = pick8(in8, sel8);
    end

    assign out2 = out2_d;
    assign out4 = out4_d;
    assign out8 = out8_d;

    // Registered copies: cleared immediately by rst_n, otherwise one-cycle delay.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out2_q <= {WIDTH{1'b0}};
            out4_q <= {WIDTH{1'b0}};
            out8_q <= {WIDTH{1'b0}};
        end else begin
            out2_q <= out2_d;
            out4_q <= out4_d;
            out8_q <= out8_d;
        end
    end

endmodule

// File: tb/tb_mux_2_4_8.sv
module tb_mux_2_4_8;

    localparam int WIDTH = 1;

    logic             clk;
    logic             rst_n;
    logic [WIDTH-1:0] in0;
    logic [WIDTH-1:0] in1;
    logic             sel2;
    logic [3:0]       in4;
    logic [1:0]       sel4;
    logic [7:0]       in8;
    logic [2:0]       sel8;
    logic [WIDTH-1:0] out2;
    logic [WIDTH-1:0] out4;
    logic [WIDTH-1:0] out8;
    logic [WIDTH-1:0] out2_q;
    logic [WIDTH-1:0] out4_q;
    logic [WIDTH-1:0] out8_q;

    int n_pass;
    int n_total;

    mux_2_4_8 #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .in0    (in0),
        .in1    (in1),
        .sel2   (sel2),
        .in4    (in4),
        .sel4   (sel4),
        .in8    (in8),
        .sel8   (sel8),
        .out2   (out2),
        .out4   (out4),
        .out8   (out8),
        .out2_q (out2_q),
        .out4_q (out4_q),
        .out8_q (out8_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered outputs must be zero under reset, including across a clock edge.
    task automatic test_reset();
        logic [2:0] q;
        rst_n = 1'b0;
        in0 = 1'b1; in1 = 1'b1; sel2 = 1'b0;
        in4 = 4'b1111; sel4 = 2'd0;
        in8 = 8'hFF; sel8 = 3'd0;
        #1;
        q = {out2_q, out4_q, out8_q};
        n_total++;
        if (q !== 3'b000) $display("FAIL reset_initial q=%b exp=000", q);
        else n_pass++;
        @(posedge clk); #1;
        q = {out2_q, out4_q, out8_q};
        n_total++;
        if (q !== 3'b000) $display("FAIL reset_hold_edge q=%b exp=000", q);
        else n_pass++;
        // comb path is live under reset
        n_total++;
        if ({out2, out4, out8} !== 3'b111) $display("FAIL reset_comb_live outs=%b exp=111", {out2, out4, out8});
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        // first edge after release loads normally
        @(posedge clk); #1;
        q = {out2_q, out4_q, out8_q};
        n_total++;
        if (q !== 3'b111) $display("FAIL reset_first_load q=%b exp=111", q);
        else n_pass++;
    endtask

    task automatic test_mux2();
        logic [1:0] exp_v [2] = '{1'b0, 1'b1};
        in0 = 1'b0; in1 = 1'b1;
        for (int s = 0; s < 2; s++) begin
            @(negedge clk);
            sel2 = s[0];
            #1;
            n_total++;
            if (out2 !== exp_v[s][0]) $display("FAIL mux2_sel%0d out2=%b exp=%b", s, out2, exp_v[s][0]);
            else n_pass++;
        end
        // swapped data
        in0 = 1'b1; in1 = 1'b0; sel2 = 1'b0; #1;
        n_total++;
        if (out2 !== 1'b1) $display("FAIL mux2_swap out2=%b exp=1", out2);
        else n_pass++;
    endtask

    task automatic test_mux4();
        logic exp_v [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        in4 = 4'b1010;
        for (int s = 0; s < 4; s++) begin
            @(negedge clk);
            sel4 = s[1:0];
            #1;
            n_total++;
            if (out4 !== exp_v[s]) $display("FAIL mux4_sel%0d out4=%b exp=%b", s, out4, exp_v[s]);
            else n_pass++;
        end
        in4 = 4'b0100; sel4 = 2'd2; #1;
        n_total++;
        if (out4 !== 1'b1) $display("FAIL mux4_onehot2 out4=%b exp=1", out4);
        else n_pass++;
    endtask

    task automatic test_mux8();
        logic [2:0] sels  [4] = '{3'd0, 3'd3, 3'd6, 3'd7};
        logic       exp_v [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        in8 = 8'b10101010;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            sel8 = sels[k];
            #1;
            n_total++;
            if (out8 !== exp_v[k]) $display("FAIL mux8_sel%0d out8=%b exp=%b", sels[k], out8, exp_v[k]);
            else n_pass++;
        end
    endtask

    // Changing lanes 4/8 must not disturb lane 2, and vice versa.
    task automatic test_independence();
        @(negedge clk);
        in0 = 1'b0; in1 = 1'b1; sel2 = 1'b1;
        in4 = 4'b0000; sel4 = 2'd0;
        in8 = 8'h00; sel8 = 3'd0;
        #1;
        in4 = 4'b1111; in8 = 8'hFF; sel4 = 2'd3; sel8 = 3'd5; #1;
        n_total++;
        if (out2 !== 1'b1) $display("FAIL indep_out2 out2=%b exp=1", out2);
        else n_pass++;
        sel2 = 1'b0; in1 = 1'b0; #1;
        n_total++;
        if ({out4, out8} !== 2'b11) $display("FAIL indep_out4_out8 outs=%b exp=11", {out4, out8});
        else n_pass++;
    endtask

    // Combinational change shows at once; registered copy waits for the edge.
    task automatic test_latency();
        @(negedge clk);
        in1 = 1'b0; sel2 = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        in1 = 1'b1;
        #1;
        n_total++;
        if (out2 !== 1'b1) $display("FAIL latency_comb out2=%b exp=1", out2);
        else n_pass++;
        n_total++;
        if (out2_q !== 1'b0) $display("FAIL latency_before_edge out2_q=%b exp=0", out2_q);
        else n_pass++;
        @(posedge clk); #1;
        n_total++;
        if (out2_q !== 1'b1) $display("FAIL latency_after_edge out2_q=%b exp=1", out2_q);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        in0 = 1'b0; in1 = 1'b1; sel2 = 1'b1;
        in4 = 4'b1000; sel4 = 2'd3;
        in8 = 8'h10; sel8 = 3'd4;
        @(posedge clk); #1;
        n_total++;
        if ({out2_q, out4_q, out8_q} !== 3'b111) $display("FAIL async_preload q=%b exp=111", {out2_q, out4_q, out8_q});
        else n_pass++;
        #2;
        rst_n = 1'b0;
        #1;
        n_total++;
        if ({out2_q, out4_q, out8_q} !== 3'b000) $display("FAIL async_clear q=%b exp=000", {out2_q, out4_q, out8_q});
        else n_pass++;
        n_total++;
        if ({out2, out4, out8} !== 3'b111) $display("FAIL async_comb_unchanged outs=%b exp=111", {out2, out4, out8});
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_sweep();
        logic exp_c;
        for (int hot = 0; hot < 8; hot++) begin
            for (int s = 0; s < 8; s++) begin
                @(negedge clk);
                in8  = 8'b1 << hot;
                sel8 = s[2:0];
                exp_c = (hot == s);
                #1;
                n_total++;
                if (out8 !== exp_c) $display("FAIL sweep_comb hot=%0d sel=%0d out8=%b exp=%b", hot, s, out8, exp_c);
                else n_pass++;
                @(posedge clk); #1;
                n_total++;
                if (out8_q !== exp_c) $display("FAIL sweep_q hot=%0d sel=%0d out8_q=%b exp=%b", hot, s, out8_q, exp_c);
                else n_pass++;
            end
        end
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        test_reset();
        test_mux2();
        test_mux4();
        test_mux8();
        test_independence();
        test_latency();
        test_async_reset();
        test_sweep();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mux_2_4_8.md
MUX_2_4_8 -- requirements
Module: mux_2_4_8

Interface
REQ-001 The block SHALL have parameter WIDTH, default 1, giving the bit width of each data lane; 1 is the only value verified.
REQ-002 The block SHALL have port clk, input, 1, the single system clock; all registers update on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, an asynchronous active-low reset.
REQ-004 The block SHALL have port in0, input, WIDTH, the 2:1 lane, input 0.
REQ-005 The block SHALL have port in1, input, WIDTH, the 2:1 lane, input 1.
REQ-006 The block SHALL have port sel2, input, 1, the 2:1 select.
REQ-007 The block SHALL have port in4, input, 4*WIDTH, the 4:1 lane inputs; slice k = in4[k*WIDTH +: WIDTH].
REQ-008 The block SHALL have port sel4, input, 2, the 4:1 select.
REQ-009 The block SHALL have port in8, input, 8*WIDTH, the 8:1 lane inputs; slice k = in8[k*WIDTH +: WIDTH].
REQ-010 The block SHALL have port sel8, input, 3, the 8:1 select.
REQ-011 The block SHALL have port out2, output, WIDTH, the combinational 2:1 result.
REQ-012 The block SHALL have port out4, output, WIDTH, the combinational 4:1 result.
REQ-013 The block SHALL have port out8, output, WIDTH, the combinational 8:1 result.
REQ-014 The block SHALL have port out2_q, output, WIDTH, out2 registered.
REQ-015 The block SHALL have port out4_q, output, WIDTH, out4 registered.
REQ-016 The block SHALL have port out8_q, output, WIDTH, out8 registered.

Function
REQ-017 out2 SHALL equal in0 when sel2=0 and in1 when sel2=1, purely combinationally, with zero cycle latency.
REQ-018 out4 SHALL equal slice sel4 of in4 (sel4 unsigned), purely combinationally.
REQ-019 out8 SHALL equal slice sel8 of in8 (sel8 unsigned), purely combinationally.
REQ-020 Every select encoding SHALL be legal: no out-of-range case exists and no default/latch is inferred.
REQ-021 The three lanes SHALL be fully independent: no input of one lane affects another lane's outputs.
REQ-022 The combinational outputs SHALL NOT depend on clk or rst_n.
REQ-023 On each rising clk edge with rst_n=1, out2_q/out4_q/out8_q SHALL load the current out2/out4/out8, giving exactly one cycle of latency.
REQ-024 A select or data change between clock edges SHALL affect only the combinational outputs until the next rising edge.
REQ-025 A select with X/Z bits is outside the defined behaviour; the block SHALL NOT need to handle it.

Reset
REQ-026 When rst_n=0, out2_q, out4_q and out8_q SHALL clear to all zeros immediately, without waiting for a clock edge.
REQ-027 The registered outputs SHALL hold zero while rst_n=0, regardless of clk.
REQ-028 After rst_n is deasserted, the first rising edge SHALL load the registered outputs normally.
REQ-029 Reset asserted mid-operation SHALL clear the registered outputs at once and SHALL leave the combinational outputs unaffected.

Verification
REQ-030 The bench SHALL cover the 2:1 case: in0=0, in1=1; sel2=0 -> out2=0; sel2=1 -> out2=1.
REQ-031 The bench SHALL cover the 4:1 case: in4=4'b1010; sel4=00/01/10/11 -> out4=0/1/0/1.
REQ-032 The bench SHALL cover the 8:1 case: in8=8'b10101010; sel8=000/011/110/111 -> out8=0/1/0/1.
REQ-033 The bench SHALL check registered latency: sel2=1, in1=1 -> out2 is 1 immediately; out2_q is 1 only after the next rising clk edge.
REQ-034 The bench SHALL check async reset: with all *_q=1, drive rst_n=0 between edges -> all *_q=0 immediately, and out2/out4/out8 are unchanged.
REQ-035 The bench SHALL run an exhaustive sweep: all sel8 values with one-hot in8 -> out8=1 only when sel8 equals the hot index, and out8_q matches one cycle later.
